// File: rtl/tdm_demux8.sv
// tdm_demux8 -- serial TDM slot demultiplexer (inverse of an 8:1 selector).
// Collects eight serial slots, marked by a sync beat on slot 0, into one
// registered parallel byte o, where o[k] = slot k.
// Optional feature: define TDM_DEMUX_PARITY_EN to add a ninth even-parity
// beat per frame, the PAR state and the parity_err pulse output.
//
// Input handshake: there is no ready. The block always accepts a beat, so
// every cycle with in_valid=1 at a rising clk edge is exactly one beat. in
// and sync are meaningful only in those cycles. Cycles with in_valid=0
// change nothing.
module tdm_demux8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic       in_valid,
  input  logic       sync,
  output logic [7:0] o,
  output logic [2:0] sel,
  output logic       busy,
  output logic       frame_done,
  output logic       sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1} state_t;
`endif

  state_t     state;
  state_t     state_next;
  logic [7:0] frame_buf;

  // Beat decode results
  logic       take_sync;   // valid sync beat: slot 0 of a new frame
  logic       take_data;   // valid non-sync beat stored into slot sel
  logic       resync_err;  // sync beat arriving while a frame is open
  logic       deliver;     // complete, accepted frame loads o this edge
  logic [7:0] frame_word;  // value loaded into o on delivery
  logic [2:0] sel_after;   // sel following a stored data beat
`ifdef TDM_DEMUX_PARITY_EN
  logic       par_beat;    // valid non-sync beat in PAR
  logic       par_bad;     // parity beat does not give even parity
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a sync beat always (re)starts a frame in RECV
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid && sync) state_next = RECV;
      end
      RECV: begin
        if (in_valid) begin
          if (sync) begin
            state_next = RECV;
          end else if (sel == 3'd7) begin
`ifdef TDM_DEMUX_PARITY_EN
            state_next = PAR;
`else
            state_next = IDLE;
`endif
          end
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      PAR: begin
        if (in_valid) state_next = sync ? RECV : IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output logic: busy whenever a frame is open
  always_comb begin
    busy = (state != IDLE);
  end

  // Beat decode: classify the current beat for the datapath
  always_comb begin
    take_sync  = in_valid && sync;
    resync_err = in_valid && sync && (state != IDLE);
    take_data  = in_valid && !sync && (state == RECV);
`ifdef TDM_DEMUX_PARITY_EN
    // slot 7 parks sel at 7 until the parity beat closes the frame
    sel_after  = (sel == 3'd7) ? 3'd7 : sel + 3'd1;
    par_beat   = in_valid && !sync && (state == PAR);
    par_bad    = par_beat && (in != ^frame_buf);
    deliver    = par_beat && (in == ^frame_buf);
    frame_word = frame_buf;
`else
    sel_after  = (sel == 3'd7) ? 3'd0 : sel + 3'd1;
    // slot 7 bypasses the buffer so o holds the whole frame at the same edge
    deliver    = take_data && (sel == 3'd7);
    frame_word = {in, frame_buf[6:0]};
`endif
  end

  // Datapath: slot buffer, slot index, parallel output and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_buf  <= 8'h00;
      o          <= 8'h00;
      sel        <= 3'd0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_done <= deliver;
      sync_err   <= resync_err;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= par_bad;
`endif
      if (deliver) o <= frame_word;
      if (take_sync) begin
        // stale slots of a discarded frame get overwritten before delivery
        frame_buf[0] <= in;
        sel          <= 3'd1;
      end else if (take_data) begin
        frame_buf[sel] <= in;
        sel            <= sel_after;
      end
`ifdef TDM_DEMUX_PARITY_EN
      else if (par_beat) begin
        sel <= 3'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8 -- directed bench for tdm_demux8 with a frame scoreboard.
// Builds with or without TDM_DEMUX_PARITY_EN.
module tb_tdm_demux8;

  logic       clk;
  logic       rst_n;
  logic       in;
  logic       in_valid;
  logic       sync;
  logic [7:0] o;
  logic [2:0] sel;
  logic       busy;
  logic       frame_done;
  logic       sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic       parity_err;
  localparam int FRAME_BEATS = 9;
`else
  localparam int FRAME_BEATS = 8;
`endif

  tdm_demux8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .in_valid   (in_valid),
    .sync       (sync),
    .o          (o),
    .sel        (sel),
    .busy       (busy),
    .frame_done (frame_done),
    .sync_err   (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         done_cyc_prev = 0;
  logic [7:0] last_o = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; sample #1 after the edge and score any delivered frame
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc_prev = done_cyc;
      done_cyc      = cyc;
      chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_frame_o", 32'(o), 32'(e));
      end
    end
  endtask

  // driver: one valid beat then deassert in_valid
  task automatic beat(input logic d, input logic s);
    in       = d;
    sync     = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic gaps(input int n, input logic [2:0] exp_sel);
    for (int g = 0; g < n; g++) begin
      tick();
      chk("gap_sel", 32'(sel), 32'(exp_sel));
      chk("gap_o", 32'(o), 32'(last_o));
    end
  endtask

  // slots start_k..7 of v, then the parity beat when enabled
  task automatic tail(input logic [7:0] v, input int start_k, input int gap, input logic bad);
    logic       fin;
    logic [2:0] es;
    for (int k = start_k; k < 8; k++) begin
      beat(v[k], 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
      fin = 1'b0;
      es  = (k < 7) ? 3'(k + 1) : 3'd7;
`else
      fin = (k == 7);
      es  = (k < 7) ? 3'(k + 1) : 3'd0;
`endif
      if (fin) last_o = v;
      chk("slot_sel", 32'(sel), 32'(es));
      chk("slot_o", 32'(o), 32'(last_o));
      chk("slot_done", 32'(frame_done), 32'(fin));
      chk("slot_busy", 32'(busy), 32'(!fin));
      chk("slot_sync_err", 32'(sync_err), 32'd0);
      gaps(gap, es);
    end
`ifdef TDM_DEMUX_PARITY_EN
    beat((^v) ^ bad, 1'b0);
    if (!bad) last_o = v;
    chk("par_done", 32'(frame_done), 32'(!bad));
    chk("par_err", 32'(parity_err), 32'(bad));
    chk("par_o", 32'(o), 32'(last_o));
    chk("par_sel", 32'(sel), 32'd0);
    chk("par_busy", 32'(busy), 32'd0);
    gaps(gap, 3'd0);
`endif
  endtask

  task automatic send_frame(input logic [7:0] v, input int gap, input logic bad);
    if (!bad) exp_q.push_back(v);
    beat(v[0], 1'b1);
    chk("sync_sel", 32'(sel), 32'd1);
    chk("sync_busy", 32'(busy), 32'd1);
    chk("sync_no_err", 32'(sync_err), 32'd0);
    gaps(gap, 3'd1);
    tail(v, 1, gap, bad);
  endtask

  initial begin
    int d0;
    logic [7:0] ff = 8'hFF;
    rst_n    = 1'b1;
    in       = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_o", 32'(o), 32'h00);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // non-sync beat in IDLE is ignored
    beat(1'b1, 1'b0);
    chk("idle_ignore_sel", 32'(sel), 32'd0);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    // continuous frame 0x55
    send_frame(8'h55, 0, 1'b0);
    tick();
    chk("f55_pulse_one_cycle", 32'(frame_done), 32'd0);

    // same frame with 3-cycle gaps: single pulse, stable o/sel in gaps
    d0 = done_cnt;
    send_frame(8'h55, 3, 1'b0);
    tick();
    chk("gap_single_pulse", 32'(done_cnt - d0), 32'd1);

    // sync at slot 4, then full frame 0x66
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) beat(ff[k], k == 0);
    exp_q.push_back(8'h66);
    beat(1'b0, 1'b1);
    chk("resync_err", 32'(sync_err), 32'd1);
    chk("resync_sel", 32'(sel), 32'd1);
    chk("resync_o", 32'(o), 32'(last_o));
    chk("resync_no_done", 32'(frame_done), 32'd0);
    tail(8'h66, 1, 0, 1'b0);
    tick();
    chk("resync_err_cleared", 32'(sync_err), 32'd0);
    chk("resync_one_frame", 32'(done_cnt - d0), 32'd1);

    // reset after slot 5
    for (int k = 0; k < 6; k++) beat(ff[k], k == 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_o", 32'(o), 32'h00);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(frame_done), 32'd0);
    tick();
    rst_n  = 1'b1;
    last_o = 8'h00;
    for (int k = 0; k < 3; k++) begin
      beat(1'b1, 1'b0);
      chk("stray_sel", 32'(sel), 32'd0);
      chk("stray_o", 32'(o), 32'h00);
      chk("stray_busy", 32'(busy), 32'd0);
    end
    send_frame(8'hC3, 0, 1'b0);

    // back-to-back frames
    send_frame(8'hA5, 0, 1'b0);
    send_frame(8'h3C, 0, 1'b0);
    chk("b2b_spacing", 32'(done_cyc - done_cyc_prev), 32'(FRAME_BEATS));
    tick();

    // sync in the slot-7 beat: old frame dropped, new frame 0x81
    d0 = done_cnt;
    for (int k = 0; k < 7; k++) beat(ff[k], k == 0);
    exp_q.push_back(8'h81);
    beat(1'b1, 1'b1);
    chk("s7sync_err", 32'(sync_err), 32'd1);
    chk("s7sync_no_done", 32'(frame_done), 32'd0);
    chk("s7sync_o", 32'(o), 32'(last_o));
    chk("s7sync_sel", 32'(sel), 32'd1);
    tail(8'h81, 1, 0, 1'b0);
    chk("s7sync_one_frame", 32'(done_cnt - d0), 32'd1);

    // random frames with random gaps
    for (int r = 0; r < 4; r++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 2), 1'b0);
    end

`ifdef TDM_DEMUX_PARITY_EN
    // parity good then bad on frame 0x55
    send_frame(8'h55, 0, 1'b0);
    d0 = done_cnt;
    send_frame(8'h55, 1, 1'b1);
    tick();
    chk("bad_par_no_done", 32'(done_cnt - d0), 32'd0);
    chk("bad_par_o", 32'(o), 32'h55);
`endif

    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
